bram_loader: RTL and testbench
==============================

BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, byte width; ADDR_W, default 3, address width; DEPTH, default 8, entries loaded (= 2**ADDR_W).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  load request pulse; sampled only in IDLE.
REQ-005 in_valid  in  1  upstream byte valid.
REQ-006 in_data  in  DATA_W  upstream byte.
REQ-007 in_ready  out  1  byte accepted when in_valid & in_ready.
REQ-008 ena  out  1  BRAM port enable.
REQ-009 wea  out  1  BRAM write enable.
REQ-010 addra  out  ADDR_W  BRAM address.
REQ-011 dina  out  DATA_W  BRAM write data.
REQ-012 douta  in  DATA_W  BRAM read data; valid one cycle after the read address is presented.
REQ-013 busy  out  1  high whenever state != IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 error  out  1  readback checksum mismatch; sticky.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-017 IDLE: in_ready=0, ena=0, wea=0; start=1 -> WRITE, ptr=0, wr_xor=0, rd_xor=0, error cleared.
REQ-018 WRITE: in_ready=1; ena=wea=in_valid; addra=ptr; dina=in_data; all combinational, zero latency.
REQ-019 WRITE: each accepted beat SHALL XOR in_data into wr_xor and increment ptr; in_valid low stalls with no port activity.
REQ-020 Accepting the beat at ptr=DEPTH-1 SHALL move the FSM to READ with ptr wrapped to 0.
REQ-021 READ: ena=1, wea=0, addra=ptr, in_ready=0; ptr increments every cycle; after issuing address DEPTH-1 -> DRAIN.
REQ-022 From the second READ cycle through DRAIN, douta SHALL be XORed into rd_xor (exactly DEPTH samples).
REQ-023 DRAIN: ena=0, wea=0; captures the final sample; -> DONE.
REQ-024 DONE: done=1 for one cycle; error <= (wr_xor != rd_xor after final sample); -> IDLE.
REQ-025 With in_valid held high, done SHALL assert exactly 2*DEPTH+2 cycles after the cycle in which start is sampled (18 at default).
REQ-026 start while busy SHALL be ignored and SHALL NOT restart or extend the sequence.
REQ-027 Address SHALL wrap modulo 2**ADDR_W; no out-of-range address is ever driven.
REQ-028 wea SHALL never be high outside WRITE; ena and wea SHALL never both be high outside WRITE.
REQ-029 error SHALL hold its value until the next accepted start or reset.

Reset
REQ-030 reset SHALL force, at the next edge, state=IDLE, ptr=0, wr_xor=0, rd_xor=0, error=0, done=0; consequently in_ready=0, ena=0, wea=0, busy=0, addra=0, dina=0.
REQ-031 reset mid-WRITE or mid-READ SHALL abandon the sequence with no done pulse; partially written BRAM contents are not restored.
REQ-032 reset SHALL take priority over start in the same cycle.

Structure
REQ-033 A shared package mem_pkg SHALL hold DATA_W/ADDR_W/DEPTH defaults and the FSM state enumeration, reused by the existing BRAM reader.
REQ-034 The block SHALL be a single module with no sub-modules; the BRAM instance lives in the parent, not inside bram_loader.

Verification
REQ-035 Bench SHALL pair bram_loader with a behavioural 1-cycle-latency 8x8 BRAM model.
REQ-036 start, bytes 0x00,0x3E,0x00,0x0C,0x00,0x18,0x00,0x60 with in_valid constant -> wea high cycles 1-8 at addra 0-7, done at cycle 18, error=0, BRAM holds those bytes.
REQ-037 Same stream with in_valid low every other cycle -> 8 writes only on valid cycles, done 8 cycles later than REQ-036, error=0.
REQ-038 Model corrupts address 5 to 0x19 on readback -> done pulse, error=1; next start with clean model -> error=0 after done.
REQ-039 reset asserted after third accepted beat -> next edge ena=wea=in_ready=busy=0, no done; fresh start completes normally.
REQ-040 start pulsed during READ and on the cycle done is high -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared BRAM geometry defaults and loader/reader FSM state codes
package mem_pkg;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 3;
  localparam int MEM_DEPTH = 2 ** MEM_ADDR_W;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_READ = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE = 3'd4;
endpackage

// File: rtl/bram_loader.sv
// bram_loader: streams DEPTH bytes into an external BRAM, reads them back and checks an XOR checksum
// ports: clk/reset (sync, active-high); start load request; in_valid/in_data/in_ready upstream byte stream;
//        ena/wea/addra/dina/douta external 1-cycle-latency BRAM port; busy, done pulse, sticky error
import mem_pkg::*;
module bram_loader #(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] wr_xor, rd_xor;
  logic last;
  assign last = ptr == ADDR_W'(DEPTH - 1);
  assign in_ready = state == ST_WRITE;
  assign wea = in_ready & in_valid;
  assign ena = wea | (state == ST_READ);
  assign addra = ptr;
  assign dina = in_ready ? in_data : '0;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  // douta lags the read address by one cycle, so sampling runs from the
  // second READ cycle (ptr != 0) through DRAIN: exactly DEPTH samples
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr <= '0;
      wr_xor <= '0;
      rd_xor <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_WRITE;
          ptr <= '0;
          wr_xor <= '0;
          rd_xor <= '0;
          error <= 1'b0;
        end
        ST_WRITE: if (in_valid) begin
          wr_xor <= wr_xor ^ in_data;
          ptr <= ptr + 1'b1;
          if (last) state <= ST_READ;
        end
        ST_READ: begin
          ptr <= ptr + 1'b1;
          if (ptr != '0) rd_xor <= rd_xor ^ douta;
          if (last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          rd_xor <= rd_xor ^ douta;
          state <= ST_DONE;
        end
        ST_DONE: begin
          error <= wr_xor != rd_xor;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_loader.sv
// tb_bram_loader: table-driven and randomized checks of bram_loader against a behavioural BRAM and reference model
module tb_bram_loader;
  logic clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = 0, dina, douta = 0;
  logic in_ready, ena, wea, busy, done, error;
  logic [2:0] addra;
  int checks = 0, errors = 0;
  logic [7:0] mem [8];
  bit cor_en = 0;
  logic [2:0] cor_addr = 0;
  logic [7:0] cor_val = 0;
  bit vld [300];
  typedef struct {
    logic [7:0][7:0] data;
    int vmode;
    bit cor;
    bit spam;
    int exp_done;
    bit exp_err;
  } vec_t;
  vec_t tbl [4];

  bram_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ena) begin
    if (wea) mem[addra] <= dina;
    douta <= (cor_en && addra == cor_addr) ? cor_val : mem[addra];
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic int model_done();
    int acc = 0;
    for (int c = 1; c < 300; c++) if (vld[c]) begin
      acc++;
      if (acc == 8) return c + 8 + 2;
    end
    return -1;
  endfunction

  function automatic bit model_err(input logic [7:0][7:0] d, input bit cor, input logic [2:0] ca, input logic [7:0] cv);
    logic [7:0] wx = 0, rx = 0;
    for (int i = 0; i < 8; i++) begin
      wx ^= d[i];
      rx ^= (cor && ca == 3'(i)) ? cv : d[i];
    end
    return wx != rx;
  endfunction

  task automatic run(input string n, input logic [7:0][7:0] d, input bit cor, input logic [2:0] ca,
                     input logic [7:0] cv, input bit spam, input int exp_done, input bit exp_err);
    int acc = 0, nwr = 0, nrd = 0, bad = 0, got = -1, extra = 0, held = 0;
    cor_en = cor; cor_addr = ca; cor_val = cv;
    @(posedge clk); #1 start = 1; in_valid = 0;
    @(negedge clk);
    if (busy || in_ready || ena || wea) bad++;
    for (int c = 1; c < 300 && got < 0; c++) begin
      @(posedge clk); #1;
      start = spam;
      in_valid = vld[c];
      in_data = acc < 8 ? d[acc] : 8'($urandom);
      @(negedge clk);
      if (wea) begin
        if (nwr >= 8 || addra != 3'(nwr) || dina != d[nwr] || !(acc < 8 && in_valid)) bad++;
        nwr++;
      end else if (ena) begin
        if (acc < 8 || addra != 3'(nrd)) bad++;
        nrd++;
      end
      if (acc < 8 && in_valid && !wea) bad++;
      if (!busy) bad++;
      if (done) got = c;
      if (in_valid && acc < 8) acc++;
    end
    start = 0; in_valid = 0;
    chk({n, "_done_cycle"}, got, exp_done);
    chk({n, "_writes"}, nwr, 8);
    chk({n, "_reads"}, nrd, 8);
    chk({n, "_port_violations"}, bad, 0);
    for (int i = 0; i < 8; i++) if (mem[i] != d[i]) held++;
    chk({n, "_bram_mismatches"}, held, 0);
    @(posedge clk); @(negedge clk);
    chk({n, "_error"}, int'(error), int'(exp_err));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy || error != exp_err) extra++;
    end
    chk({n, "_quiet_after_done"}, extra, 0);
    cor_en = 0;
  endtask

  initial begin
    logic [7:0][7:0] spec_d, rd;
    int bad;
    spec_d = {8'h60, 8'h00, 8'h18, 8'h00, 8'h0C, 8'h00, 8'h3E, 8'h00};
    tbl[0] = '{spec_d, 0, 1'b0, 1'b0, 18, 1'b0};
    tbl[1] = '{spec_d, 1, 1'b0, 1'b0, 26, 1'b0};
    tbl[2] = '{spec_d, 0, 1'b1, 1'b0, 18, 1'b1};
    tbl[3] = '{spec_d, 0, 1'b0, 1'b1, 18, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {28'd0, in_ready, ena, wea, busy} | {29'd0, addra} | int'(dina), 0);
    chk("reset_done_error", {30'd0, done, error}, 0);
    #1 reset = 0;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 300; c++) vld[c] = tbl[t].vmode == 0 ? 1'b1 : (c % 2 == 0);
      run($sformatf("vec%0d", t), tbl[t].data, tbl[t].cor, 3'd5, 8'h19, tbl[t].spam, tbl[t].exp_done, tbl[t].exp_err);
    end
    // reset after the third accepted beat abandons the load
    for (int c = 0; c < 300; c++) vld[c] = 1'b1;
    @(posedge clk); #1 start = 1; in_valid = 1; in_data = 8'hA5;
    repeat (3) begin
      @(posedge clk); #1 start = 0;
    end
    reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("midreset_ports", {28'd0, ena, wea, in_ready, busy}, 0);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("midreset_no_done", bad, 0);
    // reset wins over start in the same cycle
    @(posedge clk); #1 reset = 1; start = 1;
    @(posedge clk); #1 reset = 0; start = 0; in_valid = 0;
    @(negedge clk);
    chk("reset_beats_start", int'(busy), 0);
    run("fresh", spec_d, 1'b0, 3'd0, 8'h00, 1'b0, 18, 1'b0);
    for (int r = 0; r < 6; r++) begin
      bit cor, spam;
      logic [2:0] ca;
      logic [7:0] cv;
      for (int i = 0; i < 8; i++) rd[i] = 8'($urandom);
      for (int c = 0; c < 300; c++) vld[c] = c > 0 && $urandom_range(0, 3) != 0;
      cor = 1'($urandom); spam = 1'($urandom);
      ca = 3'($urandom); cv = 8'($urandom);
      run($sformatf("rnd%0d", r), rd, cor, ca, cv, spam, model_done(), model_err(rd, cor, ca, cv));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
